// File: rtl/password_gen_pkg.sv
// password_gen_pkg: shared state type, default character range and length-width helper
package password_gen_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] CHAR_LO_DEF = 8'h21;
    localparam logic [7:0] CHAR_HI_DEF = 8'h7E;
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/char_digit.sv
// char_digit: one password position, an odometer digit with wrap-to-start and carry flag
// Ports: clock/reset; i_clr zeroes the digit, i_load loads i_load_val, i_adv advances
// by i_step (wrapping to i_start past CHAR_HI); o_value is the digit, o_last flags that
// the next advance would wrap (carry-out condition).
module char_digit
    import password_gen_pkg::*;
#(
    parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic       i_adv,
    input  logic [7:0] i_load_val,
    input  logic [7:0] i_start,
    input  logic [2:0] i_step,
    output logic [7:0] o_value,
    output logic       o_last
);
    logic [7:0] r_val;
    logic [8:0] w_next;
    assign w_next  = {1'b0, r_val} + {6'b0, i_step};
    assign o_last  = w_next > {1'b0, CHAR_HI};
    assign o_value = r_val;
    always_ff @(posedge clock) begin
        if (reset || i_clr) r_val <= 8'h00;
        else if (i_load)    r_val <= i_load_val;
        else if (i_adv)     r_val <= o_last ? i_start : w_next[7:0];
    end
endmodule

// File: rtl/password_generator.sv
// password_generator: sweeps every candidate password of growing length over a character range
// Ports: clock/reset (sync, active high); start launches a sweep, latching start_char and
// step; out_ready accepts the current candidate; valid/password/num_chars present it
// (position 0 in password[7:0], inactive bytes zero); done flags an exhausted sweep.
module password_generator
    import password_gen_pkg::*;
#(
    parameter int         MAX_CHARS = 16,
    parameter int         MIN_CHARS = 1,
    parameter logic [7:0] CHAR_LO   = CHAR_LO_DEF,
    parameter logic [7:0] CHAR_HI   = CHAR_HI_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [7:0]                           start_char,
    input  logic [2:0]                           step,
    input  logic                                 out_ready,
    output logic                                 valid,
    output logic [8*MAX_CHARS-1:0]               password,
    output logic [len_width(MAX_CHARS)-1:0]      num_chars,
    output logic                                 done
);
    localparam int NW = len_width(MAX_CHARS);
    state_t        r_state;
    logic          r_valid;
    logic          r_done;
    logic [NW-1:0] r_num;
    logic [7:0]    r_start;
    logic [2:0]    r_step;
    logic [7:0]    w_start_c;
    logic [2:0]    w_step_c;
    logic [7:0]    w_load_val;
    logic          w_accept;
    logic          w_xfer;
    logic          w_full;
    logic          w_final;
    logic          w_grow;
    logic [MAX_CHARS-1:0] w_last;
    logic [MAX_CHARS:0]   w_run;
    logic [7:0]           w_val [MAX_CHARS];
    assign w_start_c  = (start_char < CHAR_LO || start_char > CHAR_HI) ? CHAR_LO : start_char;
    assign w_step_c   = (step == 3'd0) ? 3'd1 : step;
    assign w_accept   = start && r_state != RUN;
    assign w_xfer     = r_valid && out_ready;
    assign w_load_val = w_accept ? w_start_c : r_start;
    // w_run[k]: every position below k sits on its last value (ripple carry chain)
    assign w_run[0]   = 1'b1;
    assign w_full     = w_run[r_num];
    assign w_final    = w_full && r_num == NW'(MAX_CHARS);
    assign w_grow     = w_xfer && w_full && !w_final;
    genvar k;
    for (k = 0; k < MAX_CHARS; k++) begin : g_dig
        assign w_run[k+1] = w_run[k] & w_last[k];
        assign password[8*k +: 8] = w_val[k];
        char_digit #(.CHAR_HI(CHAR_HI)) u_dig (
            .clock      (clock),
            .reset      (reset),
            .i_clr      (w_accept && (k >= MIN_CHARS)),
            .i_load     ((w_accept && (k < MIN_CHARS)) || (w_grow && r_num == NW'(k))),
            .i_adv      (w_xfer && !w_final && w_run[k] && NW'(k) < r_num),
            .i_load_val (w_load_val),
            .i_start    (r_start),
            .i_step     (r_step),
            .o_value    (w_val[k]),
            .o_last     (w_last[k])
        );
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_num   <= '0;
            r_start <= CHAR_LO;
            r_step  <= 3'd1;
        end else if (w_accept) begin
            r_state <= RUN;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_num   <= NW'(MIN_CHARS);
            r_start <= w_start_c;
            r_step  <= w_step_c;
        end else if (w_xfer && w_final) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
        end else if (w_grow) begin
            r_num   <= r_num + 1'b1;
        end
    end
    assign valid     = r_valid;
    assign done      = r_done;
    assign num_chars = r_num;
endmodule
